vector_mem_sequencer: RTL

// - Memory stage sitting directly downstream of control_unit and the scalar/vector ALUs.
// - Turns memREN/memWEN/isVector into data-cache requests: one access for LW/SW, THREADS serial accesses for VLW/VSW.
// - Drives a single-port dcache using the dREN/dWEN/dhit handshake.
// - Holds the datapath stalled (busy) until every lane has completed, then returns scalar or per-lane load data.

---
 rtl/vector_mem_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vector_mem_sequencer.sv
// Memory stage: turns LW/SW/VLW/VSW into serial dREN/dWEN/dhit dcache accesses and stalls the pipeline until all lanes finish.
// Optional build macro VMEM_LANE_MASK_EN adds a per-lane enable mask for vector ops.
module vector_mem_sequencer #(
    parameter int THREADS = 4,
    parameter int WORD_W  = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        memREN,
    input  logic                        memWEN,
    input  logic                        isVector,
    input  logic [WORD_W-1:0]           saddr,
    input  logic [THREADS*WORD_W-1:0]   vaddr,
    input  logic [WORD_W-1:0]           sstore,
    input  logic [THREADS*WORD_W-1:0]   vstore,
    input  logic                        dhit,
    input  logic [WORD_W-1:0]           dmemload,
`ifdef VMEM_LANE_MASK_EN
    input  logic [THREADS-1:0]          lane_mask,
`endif
    output logic                        dREN,
    output logic                        dWEN,
    output logic [WORD_W-1:0]           daddr,
    output logic [WORD_W-1:0]           dstore,
    output logic                        busy,
    output logic                        done,
    output logic [WORD_W-1:0]           sload,
    output logic [THREADS*WORD_W-1:0]   vload
);

    localparam int LANE_W = (THREADS > 1) ? $clog2(THREADS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [LANE_W-1:0]      lane_reg;
    logic                   op_read_reg;
    logic                   is_vec_reg;
    logic [THREADS-1:0]     mask_reg;
    logic [WORD_W-1:0]      saddr_reg;
    logic [WORD_W-1:0]      sstore_reg;
    logic [WORD_W-1:0]      vaddr_reg  [THREADS];
    logic [WORD_W-1:0]      vstore_reg [THREADS];
    logic [WORD_W-1:0]      vload_reg  [THREADS];
    logic [WORD_W-1:0]      sload_reg;
    logic                   dren_reg, dwen_reg;
    logic [WORD_W-1:0]      daddr_reg, dstore_reg;
    logic                   busy_reg, done_reg;

    logic [THREADS-1:0]     mask_in;
    logic                   first_any, next_any;
    logic [LANE_W-1:0]      first_lane, next_lane;
    logic                   req_active, last_lane, start_access, accept;
    logic [WORD_W-1:0]      cur_addr, cur_data;

`ifdef VMEM_LANE_MASK_EN
    assign mask_in = lane_mask;
`else
    assign mask_in = '1;
`endif

    assign accept       = memREN | memWEN;
    assign start_access = !isVector || first_any;
    assign req_active   = dren_reg | dwen_reg;
    assign last_lane    = !is_vec_reg || !next_any;
    assign cur_addr     = is_vec_reg ? vaddr_reg[lane_reg]  : saddr_reg;
    assign cur_data     = is_vec_reg ? vstore_reg[lane_reg] : sstore_reg;

    // Lowest enabled lane at accept, and lowest enabled lane above the current one.
    always_comb begin
        first_any  = 1'b0;
        first_lane = '0;
        next_any   = 1'b0;
        next_lane  = lane_reg;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (mask_in[i]) begin
                first_any  = 1'b1;
                first_lane = LANE_W'(i);
            end
            if (mask_reg[i] && (LANE_W'(i) > lane_reg)) begin
                next_any  = 1'b1;
                next_lane = LANE_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = start_access ? ACCESS : DONE;
            ACCESS:  if (req_active && dhit && last_lane) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lane_reg    <= '0;
            op_read_reg <= 1'b0;
            is_vec_reg  <= 1'b0;
            mask_reg    <= '0;
            saddr_reg   <= '0;
            sstore_reg  <= '0;
            sload_reg   <= '0;
            dren_reg    <= 1'b0;
            dwen_reg    <= 1'b0;
            daddr_reg   <= '0;
            dstore_reg  <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            for (int i = 0; i < THREADS; i++) begin
                vaddr_reg[i]  <= '0;
                vstore_reg[i] <= '0;
                vload_reg[i]  <= '0;
            end
        end else begin
            busy_reg <= (state_next == ACCESS);
            done_reg <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_read_reg <= memREN;
                        is_vec_reg  <= isVector;
                        mask_reg    <= mask_in;
                        saddr_reg   <= saddr;
                        sstore_reg  <= sstore;
                        lane_reg    <= isVector ? first_lane : '0;
                        for (int i = 0; i < THREADS; i++) begin
                            vaddr_reg[i]  <= vaddr[i*WORD_W +: WORD_W];
                            vstore_reg[i] <= vstore[i*WORD_W +: WORD_W];
                        end
                    end
                end
                ACCESS: begin
                    // First ACCESS cycle raises the request; later lanes chain straight on from each dhit.
                    if (!req_active) begin
                        dren_reg   <= op_read_reg;
                        dwen_reg   <= !op_read_reg;
                        daddr_reg  <= cur_addr;
                        dstore_reg <= cur_data;
                    end else if (dhit) begin
                        if (op_read_reg) begin
                            if (is_vec_reg) vload_reg[lane_reg] <= dmemload;
                            else            sload_reg           <= dmemload;
                        end
                        if (last_lane) begin
                            dren_reg <= 1'b0;
                            dwen_reg <= 1'b0;
                        end else begin
                            lane_reg   <= next_lane;
                            daddr_reg  <= vaddr_reg[next_lane];
                            dstore_reg <= vstore_reg[next_lane];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dREN   = dren_reg;
    assign dWEN   = dwen_reg;
    assign daddr  = daddr_reg;
    assign dstore = dstore_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign sload  = sload_reg;

    generate
        for (genvar gi = 0; gi < THREADS; gi++) begin : g_vload
            assign vload[gi*WORD_W +: WORD_W] = vload_reg[gi];
        end
    endgenerate

endmodule
